static_object_timer: RTL and testbench

- Upstream stage of the sticky alert latch (pulse-to-level) in the object-detection AXI path.
- Once per video frame, samples the detected object's centroid and tracks how long it stays within a pixel tolerance of an anchor position.
- After STABLE_FRAMES consecutive stable frames, emits a single-cycle alert_pulse; the latch stage converts this into a persistent alert level.

---
 rtl/static_object_timer.sv | 166 ++++++++++++++++
 tb/tb_static_object_timer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/static_object_timer.sv
`default_nettype none
// ============================================================================
//  Module      : static_object_timer
//  Description : Once per frame, compares the detected object's centroid
//                against a fixed anchor position. After STABLE_FRAMES
//                consecutive frames within TOL pixels of the anchor, emits a
//                one-cycle alert_pulse for the downstream sticky alert latch.
//                Optional macro STATIC_OBJ_MISS_TOLERANCE_EN lets up to
//                MISS_MAX consecutive missing-object frames pass without
//                losing track of the object.
//  Revision    : 1.0 - initial release
// ============================================================================
module static_object_timer #(
  parameter int X_W           = 11,
  parameter int Y_W           = 10,
  parameter int TOL           = 8,
  parameter int STABLE_FRAMES = 150,
  parameter int CNT_W         = 8,
  parameter int MISS_MAX      = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             frame_done,
  input  logic             obj_valid,
  input  logic [X_W-1:0]   obj_x,
  input  logic [Y_W-1:0]   obj_y,
  output logic             alert_pulse,
  output logic [CNT_W-1:0] stable_count,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_TRACK   = 2'd1,
    S_ALERTED = 2'd2,
    S_ILLEGAL = 2'd3
  } state_t;

  // Thresholds widened by one bit so they sit alongside the signed differences.
  localparam logic [X_W:0]   TOL_X      = TOL[X_W:0];
  localparam logic [Y_W:0]   TOL_Y      = TOL[Y_W:0];
  localparam logic [CNT_W:0] STABLE_TGT = STABLE_FRAMES[CNT_W:0];
  localparam logic [CNT_W-1:0] STABLE_SAT = STABLE_FRAMES[CNT_W-1:0];
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [X_W-1:0]   anchor_x_q, anchor_x_d;
  logic [Y_W-1:0]   anchor_y_q, anchor_y_d;
  logic [CNT_W-1:0] stable_count_q, stable_count_d;
  logic             alert_pulse_q, alert_pulse_d;

  logic [X_W:0]     dx, dx_abs;
  logic [Y_W:0]     dy, dy_abs;
  logic             is_stable;
  logic [CNT_W:0]   count_inc;

`ifdef STATIC_OBJ_MISS_TOLERANCE_EN
  localparam int MISS_W = (MISS_MAX < 2) ? 1 : $clog2(MISS_MAX + 1);
  localparam logic [MISS_W-1:0] MISS_LIM = MISS_MAX[MISS_W-1:0];
  logic [MISS_W-1:0] miss_q, miss_d;
`endif

  // Distance test: one extra bit of width keeps 0 vs full-scale from wrapping.
  always_comb begin
    dx     = {1'b0, obj_x} - {1'b0, anchor_x_q};
    dy     = {1'b0, obj_y} - {1'b0, anchor_y_q};
    dx_abs = dx[X_W] ? ((X_W+1)'(0) - dx) : dx;
    dy_abs = dy[Y_W] ? ((Y_W+1)'(0) - dy) : dy;
    is_stable = (dx_abs <= TOL_X) && (dy_abs <= TOL_Y);
    count_inc = {1'b0, stable_count_q} + {{CNT_W{1'b0}}, 1'b1};
  end

  // Next-state logic: everything advances only on a frame_done strobe.
  always_comb begin
    state_d        = state_q;
    anchor_x_d     = anchor_x_q;
    anchor_y_d     = anchor_y_q;
    stable_count_d = stable_count_q;
    alert_pulse_d  = 1'b0;
`ifdef STATIC_OBJ_MISS_TOLERANCE_EN
    miss_d         = miss_q;
`endif

    if (state_q == S_ILLEGAL) begin
      state_d        = S_IDLE;
      stable_count_d = '0;
    end else if (frame_done) begin
      case (state_q)
        S_IDLE: begin
          if (obj_valid) begin
            anchor_x_d     = obj_x;
            anchor_y_d     = obj_y;
            stable_count_d = CNT_ONE;
            state_d        = S_TRACK;
          end
        end
        default: begin  // S_TRACK, S_ALERTED
          if (!obj_valid) begin
`ifdef STATIC_OBJ_MISS_TOLERANCE_EN
            // Brief occlusion is tolerated; only the miss after MISS_MAX drops track.
            if (miss_q == MISS_LIM) begin
              state_d        = S_IDLE;
              stable_count_d = '0;
              miss_d         = '0;
            end else begin
              miss_d = miss_q + MISS_W'(1);
            end
`else
            state_d        = S_IDLE;
            stable_count_d = '0;
`endif
          end else begin
`ifdef STATIC_OBJ_MISS_TOLERANCE_EN
            miss_d = '0;
`endif
            if (!is_stable) begin
              // Object moved: re-anchor and restart the stationary count.
              anchor_x_d     = obj_x;
              anchor_y_d     = obj_y;
              stable_count_d = CNT_ONE;
              state_d        = S_TRACK;
            end else if (state_q == S_TRACK) begin
              // Anchor stays fixed on stable frames so slow drift cannot hide.
              stable_count_d = count_inc[CNT_W-1:0];
              if (count_inc == STABLE_TGT) begin
                alert_pulse_d = 1'b1;
                state_d       = S_ALERTED;
              end
            end else begin
              stable_count_d = STABLE_SAT;
            end
          end
        end
      endcase
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q        <= S_IDLE;
      anchor_x_q     <= '0;
      anchor_y_q     <= '0;
      stable_count_q <= '0;
      alert_pulse_q  <= 1'b0;
`ifdef STATIC_OBJ_MISS_TOLERANCE_EN
      miss_q         <= '0;
`endif
    end else begin
      state_q        <= state_d;
      anchor_x_q     <= anchor_x_d;
      anchor_y_q     <= anchor_y_d;
      stable_count_q <= stable_count_d;
      alert_pulse_q  <= alert_pulse_d;
`ifdef STATIC_OBJ_MISS_TOLERANCE_EN
      miss_q         <= miss_d;
`endif
    end
  end

  assign alert_pulse  = alert_pulse_q;
  assign stable_count = stable_count_q;
  assign state        = state_q;

endmodule
`default_nettype wire

// File: tb/tb_static_object_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_static_object_timer
//  Description : Directed self-checking bench for static_object_timer with
//                STABLE_FRAMES=4, TOL=8. Covers the occlusion-tolerance
//                branch when STATIC_OBJ_MISS_TOLERANCE_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_static_object_timer;

  localparam int X_W = 11;
  localparam int Y_W = 10;
  localparam int CNT_W = 8;

  logic             clk;
  logic             resetn;
  logic             frame_done;
  logic             obj_valid;
  logic [X_W-1:0]   obj_x;
  logic [Y_W-1:0]   obj_y;
  logic             alert_pulse;
  logic [CNT_W-1:0] stable_count;
  logic [1:0]       state;

  int n_checks = 0;
  int n_errors = 0;

  static_object_timer #(
    .X_W(X_W), .Y_W(Y_W), .TOL(8), .STABLE_FRAMES(4), .CNT_W(CNT_W), .MISS_MAX(3)
  ) dut (
    .clk(clk), .resetn(resetn), .frame_done(frame_done), .obj_valid(obj_valid),
    .obj_x(obj_x), .obj_y(obj_y), .alert_pulse(alert_pulse),
    .stable_count(stable_count), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Check all three outputs after a step.
  task automatic expect_out(input string tag, input int st, input int cnt, input int pls);
    check({tag, ".state"}, int'(state), st);
    check({tag, ".count"}, int'(stable_count), cnt);
    check({tag, ".pulse"}, int'(alert_pulse), pls);
  endtask

  // One frame_done strobe; outputs are sampled 1 time unit after the edge.
  task automatic do_frame(input logic v, input int x, input int y);
    frame_done = 1'b1;
    obj_valid  = v;
    obj_x      = X_W'(x);
    obj_y      = Y_W'(y);
    @(posedge clk); #1;
    frame_done = 1'b0;
    obj_valid  = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    frame_done = 1'b0;
    obj_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0; frame_done = 1'b0; obj_valid = 1'b0; obj_x = '0; obj_y = '0;
    #2;
    do_reset();
    expect_out("reset", 0, 0, 0);

    // 1: four stationary frames reach the threshold.
    do_frame(1, 100, 50); expect_out("t1.f1", 1, 1, 0);
    do_frame(1, 100, 50); expect_out("t1.f2", 1, 2, 0);
    do_frame(1, 100, 50); expect_out("t1.f3", 1, 3, 0);
    do_frame(1, 100, 50); expect_out("t1.f4", 2, 4, 1);
    idle_cycle();         expect_out("t1.after", 2, 4, 0);

    // 2: third frame exceeds TOL in x and re-anchors.
    do_reset();
    do_frame(1, 100, 50); expect_out("t2.f1", 1, 1, 0);
    do_frame(1, 108, 42); expect_out("t2.f2", 1, 2, 0);
    do_frame(1, 109, 50); expect_out("t2.f3", 1, 1, 0);
    do_frame(1, 117, 50); expect_out("t2.newanchor", 1, 2, 0);

    // 3: +5 px/frame drift never alerts.
    do_reset();
    do_frame(1, 100, 50); expect_out("t3.f1", 1, 1, 0);
    do_frame(1, 105, 50); expect_out("t3.f2", 1, 2, 0);
    do_frame(1, 110, 50); expect_out("t3.f3", 1, 1, 0);
    do_frame(1, 115, 50); expect_out("t3.f4", 1, 2, 0);
    do_frame(1, 120, 50); expect_out("t3.f5", 1, 1, 0);
    do_frame(1, 125, 50); expect_out("t3.f6", 1, 2, 0);

    // 4: saturation in ALERTED, then move and re-alert.
    do_reset();
    for (int i = 0; i < 3; i++) do_frame(1, 100, 50);
    do_frame(1, 100, 50); expect_out("t4.alert", 2, 4, 1);
    do_frame(1, 103, 47); expect_out("t4.sat1", 2, 4, 0);
    do_frame(1, 100, 50); expect_out("t4.sat2", 2, 4, 0);
    do_frame(1, 92, 58);  expect_out("t4.sat3", 2, 4, 0);
    do_frame(1, 300, 50); expect_out("t4.move", 1, 1, 0);
    do_frame(1, 300, 50); expect_out("t4.r2", 1, 2, 0);
    do_frame(1, 300, 50); expect_out("t4.r3", 1, 3, 0);
    do_frame(1, 300, 50); expect_out("t4.r4", 2, 4, 1);
    idle_cycle();         expect_out("t4.after", 2, 4, 0);

    // 5: missing object.
    do_reset();
    for (int i = 0; i < 3; i++) do_frame(1, 100, 50);
`ifdef STATIC_OBJ_MISS_TOLERANCE_EN
    do_frame(0, 0, 0);    expect_out("t5.m1", 1, 3, 0);
    do_frame(0, 0, 0);    expect_out("t5.m2", 1, 3, 0);
    do_frame(0, 0, 0);    expect_out("t5.m3", 1, 3, 0);
    do_frame(1, 100, 50); expect_out("t5.alert", 2, 4, 1);
    do_frame(0, 0, 0);    expect_out("t5.a1", 2, 4, 0);
    do_frame(0, 0, 0);    expect_out("t5.a2", 2, 4, 0);
    do_frame(0, 0, 0);    expect_out("t5.a3", 2, 4, 0);
    do_frame(0, 0, 0);    expect_out("t5.a4", 0, 0, 0);
`else
    do_frame(0, 0, 0);    expect_out("t5.miss", 0, 0, 0);
    do_frame(0, 0, 0);    expect_out("t5.idle", 0, 0, 0);
    // ALERTED also drops straight to IDLE.
    for (int i = 0; i < 3; i++) do_frame(1, 100, 50);
    do_frame(1, 100, 50); expect_out("t5.alert", 2, 4, 1);
    do_frame(0, 0, 0);    expect_out("t5.amiss", 0, 0, 0);
`endif

    // 6: reset coincides with the qualifying frame_done.
    do_reset();
    for (int i = 0; i < 3; i++) do_frame(1, 100, 50);
    expect_out("t6.pre", 1, 3, 0);
    resetn = 1'b0; frame_done = 1'b1; obj_valid = 1'b1; obj_x = 11'd100; obj_y = 10'd50;
    @(posedge clk); #1;
    frame_done = 1'b0; obj_valid = 1'b0; resetn = 1'b1;
    expect_out("t6.rst", 0, 0, 0);
    idle_cycle();         expect_out("t6.after", 0, 0, 0);

    // 7: full-scale distance does not wrap.
    do_reset();
    do_frame(1, 0, 0);       expect_out("t7.f1", 1, 1, 0);
    do_frame(1, 2047, 1023); expect_out("t7.far", 1, 1, 0);
    do_frame(1, 2047, 1023); expect_out("t7.same", 1, 2, 0);
    do_frame(1, 0, 0);       expect_out("t7.back", 1, 1, 0);
    do_frame(1, 0, 1023);    expect_out("t7.yonly", 1, 1, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
